// File: rtl/div_share_sched.sv
// Shared restoring divider fronted by a two-requester round-robin scheduler.
// One job in flight at a time; the response is tagged with the requester id and held until taken.
module div_share_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quotient,
    output logic [WIDTH-1:0] resp_remainder,
    output logic             resp_dbz,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic             prio_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             id_q;
    logic             dbz_q;
    logic             valid_q;
    logic             busy_q;

    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;
    logic [WIDTH-1:0] dvd_sel_c;
    logic [WIDTH-1:0] dsr_sel_c;
    logic [WIDTH:0]   shift_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // Round-robin grant: a lone requester always wins, prio_q breaks ties.
    always_comb begin
        grant0_c  = req0_valid & (~req1_valid | ~prio_q);
        grant1_c  = req1_valid & (~req0_valid |  prio_q);
        accept_c  = (state_q == IDLE) & (req0_valid | req1_valid);
        dvd_sel_c = grant1_c ? req1_dividend : req0_dividend;
        dsr_sel_c = grant1_c ? req1_divisor  : req0_divisor;
    end

    assign req0_ready = (state_q == IDLE) & grant0_c;
    assign req1_ready = (state_q == IDLE) & grant1_c;

    // One restoring step; a negative trial (MSB set) keeps the shifted remainder.
    always_comb begin
        shift_c = {rem_q, quo_q[WIDTH-1]};
        trial_c = shift_c - {1'b0, dsr_q};
        rem_d   = trial_c[WIDTH] ? shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
    end

    // resp_valid rises one cycle after entering DONE so all fields are settled first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            id_q    <= 1'b0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        id_q   <= grant1_c;
                        prio_q <= ~grant1_c;
                        busy_q <= 1'b1;
                        if (dsr_sel_c == '0) begin
                            quo_q   <= '1;
                            rem_q   <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q   <= dvd_sel_c;
                            rem_q   <= '0;
                            dsr_q   <= dsr_sel_c;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (resp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid     = valid_q;
    assign resp_id        = id_q;
    assign resp_quotient  = quo_q;
    assign resp_remainder = rem_q;
    assign resp_dbz       = dbz_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Directed and randomized checks of div_share_sched against a floor/mod reference
// with a round-robin arbitration model.
module tb_div_share_sched;

    localparam int unsigned WIDTH = 4;
    localparam int          ONES  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic             resp_valid, resp_ready, resp_id, resp_dbz, busy;
    logic [WIDTH-1:0] resp_quotient, resp_remainder;

    int n_cmp = 0;
    int n_err = 0;
    int prio_m = 0;

    div_share_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_dbz(resp_dbz), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? ONES : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? ONES : a % b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        prio_m = 0;
    endtask

    task automatic offer(input int id, input int a, input int b);
        req0_valid = (id == 0);
        req1_valid = (id == 1);
        if (id == 0) begin
            req0_dividend = WIDTH'(a);
            req0_divisor  = WIDTH'(b);
        end else begin
            req1_dividend = WIDTH'(a);
            req1_divisor  = WIDTH'(b);
        end
    endtask

    // Issue one job from a single requester and check latency and all response fields.
    task automatic run_job(input string tag, input int id, input int a, input int b);
        int lat;
        offer(id, a, b);
        #1;
        chk({tag, "_ready"}, (id == 1) ? req1_ready : req0_ready, 1);
        chk({tag, "_other_ready"}, (id == 1) ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        prio_m = 1 - id;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : WIDTH + 1);
        chk({tag, "_id"}, resp_id, id);
        chk({tag, "_q"}, resp_quotient, ref_q(a, b));
        chk({tag, "_r"}, resp_remainder, ref_r(a, b));
        chk({tag, "_dbz"}, resp_dbz, (b == 0) ? 1 : 0);
    endtask

    initial begin
        int ha[2], oa[2], ob[2];
        int sb[$];
        int idx, done_cnt, cyc, g, e, w;
        bit hs;
        bit busy_m;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_dividend = 0; req0_divisor = 0; req1_dividend = 0; req1_divisor = 0;
        do_reset();

        // Reset state
        chk("rst_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_q", resp_quotient, 0);
        chk("rst_r", resp_remainder, 0);
        chk("rst_dbz", resp_dbz, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // Single job and divide-by-zero
        resp_ready = 1'b1;
        run_job("single", 0, 13, 4);
        tick();
        chk("single_hs_valid", resp_valid, 0);
        chk("single_hs_busy", busy, 0);
        run_job("dbz", 1, 9, 0);
        tick();
        chk("dbz_hs_valid", resp_valid, 0);
        chk("dbz_hs_busy", busy, 0);

        // Contention: strict alternation starting at requester 0
        do_reset();
        resp_ready = 1'b1;
        req0_dividend = 15; req0_divisor = 1; req0_valid = 1;
        req1_dividend = 7;  req1_divisor = 3; req1_valid = 1;
        #1;
        for (int j = 0; j < 4; j++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 40) begin
                tick();
                w++;
            end
            chk("cont_ready0", req0_ready, (j % 2 == 0) ? 1 : 0);
            chk("cont_ready1", req1_ready, (j % 2 == 1) ? 1 : 0);
            tick();
            w = 0;
            while (!resp_valid && w < 40) begin
                tick();
                w++;
            end
            chk("cont_id", resp_id, j % 2);
            chk("cont_q", resp_quotient, (j % 2 == 0) ? 15 : 2);
            chk("cont_r", resp_remainder, (j % 2 == 0) ? 0 : 1);
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        prio_m = 0;

        // Backpressure: response held for 10 cycles, then taken
        resp_ready = 1'b0;
        run_job("bp", 0, 0, 7);
        req0_dividend = 3; req0_divisor = 1; req0_valid = 1;
        req1_dividend = 5; req1_divisor = 2; req1_valid = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", resp_valid, 1);
            chk("bp_q", resp_quotient, 0);
            chk("bp_r", resp_remainder, 0);
            chk("bp_id", resp_id, 0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        req0_valid = 0;
        req1_valid = 0;
        resp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", resp_valid, 0);
        chk("bp_hs_busy", busy, 0);

        // Reset mid-CALC drops the job and restores priority to requester 0
        offer(0, 14, 5);
        tick();
        req0_valid = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prio_m = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", resp_valid, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("midrst_noresp", resp_valid, 0);
        end
        req0_valid = 1;
        req1_valid = 1;
        #1;
        chk("midrst_prio0", req0_ready, 1);
        chk("midrst_prio1", req1_ready, 0);
        req0_valid = 0;
        req1_valid = 0;
        run_job("after_rst", 1, 6, 6);
        tick();

        // Exhaustive operand sweep with random requesters and response stalls
        idx = 0; done_cnt = 0; cyc = 0; busy_m = 0;
        ha[0] = 0; ha[1] = 0;
        while (done_cnt < 256 && cyc < 30000) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            hs = resp_valid && resp_ready;
            if (hs) begin
                chk("exh_pending", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("exh_id", resp_id, (e >> 8) & 1);
                    chk("exh_q", resp_quotient, ref_q((e >> 4) & 15, e & 15));
                    chk("exh_r", resp_remainder, ref_r((e >> 4) & 15, e & 15));
                    chk("exh_dbz", resp_dbz, ((e & 15) == 0) ? 1 : 0);
                    done_cnt++;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (!ha[n] && idx < 256 && $urandom_range(0, 1) == 1) begin
                    ha[n] = 1;
                    oa[n] = idx >> 4;
                    ob[n] = idx & 15;
                    idx++;
                end
                if (!ha[n]) begin
                    oa[n] = int'($urandom_range(0, ONES));
                    ob[n] = int'($urandom_range(0, ONES));
                end
            end
            req0_valid = ha[0][0]; req0_dividend = WIDTH'(oa[0]); req0_divisor = WIDTH'(ob[0]);
            req1_valid = ha[1][0]; req1_dividend = WIDTH'(oa[1]); req1_divisor = WIDTH'(ob[1]);
            #1;
            g = -1;
            if (!busy_m) begin
                if (ha[0] != 0 && ha[1] != 0) g = prio_m;
                else if (ha[0] != 0) g = 0;
                else if (ha[1] != 0) g = 1;
            end
            chk("exh_ready0", req0_ready, (g == 0) ? 1 : 0);
            chk("exh_ready1", req1_ready, (g == 1) ? 1 : 0);
            if (hs) busy_m = 0;
            if (g >= 0) begin
                sb.push_back((g << 8) | (oa[g] << 4) | ob[g]);
                busy_m = 1;
                prio_m = 1 - g;
                ha[g] = 0;
            end
            tick();
            cyc++;
        end
        chk("exh_all_done", done_cnt, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_share_sched.md
# div_share_sched

Shared iterative unsigned divider with a two-requester round-robin scheduler. Two client ports present dividend/divisor pairs with a valid/ready handshake. The scheduler grants one request at a time to a single shift-subtract divider core. The result returns on one response port tagged with the requester ID and held under backpressure. The block sits between the Tiny Tapeout I/O front end and any logic needing division, replacing one combinational divider per client.

## Interface
- WIDTH, 4: operand, quotient and remainder width in bits (≥2).
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 accepted this cycle (valid & ready = handshake).
- req0_dividend  input  WIDTH  requester 0 dividend.
- req0_divisor  input  WIDTH  requester 0 divisor.
- req1_valid / req1_ready / req1_dividend / req1_divisor: same as requester 0, for requester 1.
- resp_valid  output  1  response fields valid.
- resp_ready  input  1  consumer takes the response (valid & ready = handshake).
- resp_id  output  1  requester that issued the job (0 or 1).
- resp_quotient  output  WIDTH  floor(dividend / divisor); all ones on divide-by-zero.
- resp_remainder  output  WIDTH  dividend mod divisor; all ones on divide-by-zero.
- resp_dbz  output  1  divisor was zero.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, CALC, DONE. Reset enters IDLE.
- Grant in IDLE (combinational):
  - If only one valid is high, that requester wins.
  - If both are high, the requester selected by priority pointer `prio` wins.
  - `reqN_ready` = (state == IDLE) & granted-to-N. At most one ready is high.
  - Ready is low in CALC and DONE.
- On acceptance:
  - Latch the operands and `resp_id`.
  - Set `prio` to the requester not just granted.
  - If divisor == 0: go to DONE with quotient = remainder = all ones and `resp_dbz` = 1.
  - Otherwise go to CALC with the iteration counter at 0, partial remainder (WIDTH+1 bits) at 0, and the quotient register loaded with the dividend.
- CALC, one restoring step per cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial subtract the divisor from the partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; else restore and set the LSB to 0.
  - After WIDTH steps, go to DONE.
- DONE:
  - `resp_valid` = 1 and all response fields are stable.
  - On resp_valid & resp_ready, go to IDLE.
  - While resp_ready stays low, hold indefinitely with fields unchanged.
- Requester inputs are ignored outside the acceptance cycle. Changing operands mid-job has no effect.
- Arithmetic is exact for all 2^(2·WIDTH) operand pairs. The remainder is always < divisor when divisor ≠ 0.

## Timing
- Reset values:
  - State IDLE; `prio` = requester 0.
  - resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz and busy all 0.
  - req0_ready / req1_ready follow the grant logic, so a valid may be accepted in the first cycle after reset.
- Latency (acceptance edge = edge 0):
  - Normal job: resp_valid is high after edge WIDTH+1 (edge 5 for WIDTH=4).
  - Divide-by-zero job: resp_valid is high after edge 1.
- Throughput:
  - The next acceptance can occur at the earliest on the edge after the response handshake edge.
  - Best case is one job per WIDTH+3 cycles.
- rst asserted in any state takes effect on the next edge:
  - The in-flight job is dropped and no response is issued.
  - `prio` returns to requester 0.
- rst has priority over all handshakes in the same cycle.
- Both requesters valid in consecutive jobs: grants alternate strictly 0,1,0,1…
- A requester that deasserts valid without a handshake loses nothing; the pointer moves only on acceptance.

## Test plan
- Single job: req0 13/4 → req0_ready on the acceptance cycle; resp_valid after edge 5 with id=0, q=3, r=1, dbz=0.
- Divide by zero: req1 9/0 → resp_valid after edge 1 with id=1, q=15, r=15, dbz=1.
- Contention: both valid continuously (req0 15/1, req1 7/3), resp_ready=1 → responses alternate id 0 (q=15, r=0) then id 1 (q=2, r=1), starting with id 0 after reset.
- Backpressure: job 0/7 with resp_ready=0 for 10 cycles → resp_valid stays high, fields stay constant (q=0, r=0), both ready outputs stay low; handshake on the 11th cycle returns to IDLE the next cycle.
- Reset mid-CALC: accept 14/5, assert rst at edge 2 → no response, busy=0 and prio=0 after the reset edge; a following req1 6/6 yields q=1, r=0.
- Exhaustive: all 256 operand pairs through random requesters with random resp_ready stalls → every response matches the reference floor/mod (dbz rule for divisor 0), and ids match issue order.
